// File: rtl/fifo_pair_packer_if.sv
// Handshake bundle between the pair packer, the sync FIFO read port and the
// downstream valid/ready consumer. The packer uses the master view; the
// environment (FIFO plus consumer) uses the slave view.
interface fifo_pair_packer_if #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
);
   logic                      fifo_empty;
   logic [FIFO_WIDTH-1:0]     fifo_data_out;
   logic                      fifo_rd_en;
   logic [2*FIFO_WIDTH-1:0]   out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_partial;
   logic                      flush;
   logic [CNT_WIDTH-1:0]      out_count;

   modport master (
      input  fifo_empty,
      input  fifo_data_out,
      input  out_ready,
      input  flush,
      output fifo_rd_en,
      output out_data,
      output out_valid,
      output out_partial,
      output out_count
   );

   modport slave (
      output fifo_empty,
      output fifo_data_out,
      output out_ready,
      output flush,
      input  fifo_rd_en,
      input  out_data,
      input  out_valid,
      input  out_partial,
      input  out_count
   );
endinterface

// File: rtl/fifo_pair_packer.sv
// Read-side consumer of a sync FIFO with one cycle read latency. Pops words
// (never while empty), pairs consecutive words into one double-width output
// word and hands it downstream over valid/ready. A flush drains a lone held
// half as a zero-padded partial word. Sustains one pop per cycle.
module fifo_pair_packer #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input logic                clk,
   input logic                rst,
   fifo_pair_packer_if.master bus
);

   // Older half waiting for its partner.
   logic [FIFO_WIDTH-1:0]   lo_q;
   logic                    lo_valid;
   // A pop was issued last cycle, so fifo_data_out carries a word now.
   logic                    rd_pend;

   logic [2*FIFO_WIDTH-1:0] out_data_q;
   logic                    out_valid_q;
   logic                    out_partial_q;
   logic [CNT_WIDTH-1:0]    out_count_q;

   logic                    stalled;
   logic                    xfer;
   logic                    pop;
   logic                    flush_go;
   logic [2:0]              occ;

   // Newer half goes in the upper bits, older half in the lower bits.
   function automatic logic [2*FIFO_WIDTH-1:0] pack_pair(
      input logic [FIFO_WIDTH-1:0] newer,
      input logic [FIFO_WIDTH-1:0] older
   );
      return {newer, older};
   endfunction

   // A lone half is emitted with a zero upper half.
   function automatic logic [2*FIFO_WIDTH-1:0] pad_lone(
      input logic [FIFO_WIDTH-1:0] older
   );
      return {{FIFO_WIDTH{1'b0}}, older};
   endfunction

   // Pop decision: count the half-word slots already committed (a stalled
   // output word counts as two, plus a held half, plus one in flight) and
   // only pop while fewer than three are committed. That guarantees a
   // returning word always has somewhere to land without overwriting.
   always_comb begin
      stalled  = out_valid_q && !bus.out_ready;
      xfer     = out_valid_q && bus.out_ready;
      occ      = {1'b0, stalled, 1'b0} + {2'b00, lo_valid} + {2'b00, rd_pend};
      pop      = !rst && !bus.fifo_empty && !bus.flush && (occ < 3'd3);
      flush_go = bus.flush && !rd_pend && lo_valid && !stalled;
   end

   assign bus.fifo_rd_en  = pop;
   assign bus.out_data    = out_data_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_partial = out_partial_q;
   assign bus.out_count   = out_count_q;

   // Capture the first half of a pair when it returns from the FIFO.
   always_ff @(posedge clk) begin
      if (rd_pend && !lo_valid) begin
         lo_q <= bus.fifo_data_out;
      end
   end

   // Read tracking, pairing, flush drain and the output handshake register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend       <= 1'b0;
         lo_valid      <= 1'b0;
         out_valid_q   <= 1'b0;
         out_partial_q <= 1'b0;
         out_data_q    <= '0;
         out_count_q   <= '0;
      end else begin
         rd_pend <= pop;

         // Accepted word leaves; a load below may refill in the same cycle.
         if (xfer) begin
            out_valid_q <= 1'b0;
            out_count_q <= out_count_q + CNT_WIDTH'(1);
         end

         if (rd_pend) begin
            if (!lo_valid) begin
               lo_valid <= 1'b1;
            end else begin
               out_data_q    <= pack_pair(bus.fifo_data_out, lo_q);
               out_valid_q   <= 1'b1;
               out_partial_q <= 1'b0;
               lo_valid      <= 1'b0;
            end
         end else if (flush_go) begin
            out_data_q    <= pad_lone(lo_q);
            out_valid_q   <= 1'b1;
            out_partial_q <= 1'b1;
            lo_valid      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_pair_packer.sv
// Bench for fifo_pair_packer: a queue-based FIFO model with one cycle read
// latency feeds the packer; accepted output words and pops are logged per
// cycle and each scenario compares them with the word pairs it expects.
module tb_fifo_pair_packer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_pair_packer_if #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) bus ();

   fifo_pair_packer #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [15:0] fq[$];
   int          cyc = 0;
   int          pop_cyc[$];
   int          xfer_cyc[$];
   logic [31:0] xfer_data[$];
   logic        xfer_part[$];
   int          underflow_cnt = 0;
   int          stall_err = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_part = 1'b0;

   logic        s_rd_en, s_valid, s_part;
   logic [31:0] s_data;
   logic [15:0] s_count;

   // One clock: sample away from the edge, model the FIFO pop, log transfers.
   task automatic cycle();
      logic [15:0] w;
      logic        popped;
      popped = 1'b0;
      w = '0;
      @(negedge clk);
      s_rd_en = bus.fifo_rd_en;
      s_valid = bus.out_valid;
      s_data  = bus.out_data;
      s_part  = bus.out_partial;
      s_count = bus.out_count;
      if (prev_stall && (!s_valid || s_data !== prev_data || s_part !== prev_part))
         stall_err++;
      prev_stall = s_valid && !bus.out_ready && !rst;
      prev_data  = s_data;
      prev_part  = s_part;
      if (s_rd_en) begin
         if (fq.size() == 0) underflow_cnt++;
         else begin
            w = fq.pop_front();
            popped = 1'b1;
         end
         pop_cyc.push_back(cyc);
      end
      if (s_valid && bus.out_ready && !rst) begin
         xfer_cyc.push_back(cyc);
         xfer_data.push_back(s_data);
         xfer_part.push_back(s_part);
      end
      @(posedge clk);
      #1;
      bus.fifo_data_out = popped ? w : 16'($urandom);
      bus.fifo_empty    = (fq.size() == 0);
      cyc++;
   endtask

   task automatic push_word(input logic [15:0] w);
      fq.push_back(w);
      bus.fifo_empty = 1'b0;
   endtask

   task automatic clear_obs();
      pop_cyc.delete();
      xfer_cyc.delete();
      xfer_data.delete();
      xfer_part.delete();
      underflow_cnt = 0;
      stall_err = 0;
      prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      fq.delete();
      bus.fifo_empty = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      clear_obs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      push_word(16'h1234);
      push_word(16'h5678);
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++; if (s_rd_en !== 1'b0) $display("FAIL reset_rd_en cyc%0d got %b want 0", i, s_rd_en); else passed++;
         checks++; if (s_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got %b want 0", i, s_valid); else passed++;
         checks++; if (s_count !== 16'd0) $display("FAIL reset_count cyc%0d got %0d want 0", i, s_count); else passed++;
      end
   endtask

   task automatic test_stream();
      do_reset();
      push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
      bus.out_ready = 1'b1;
      repeat (12) cycle();
      checks++; if (pop_cyc.size() !== 4) $display("FAIL stream_pops got %0d want 4", pop_cyc.size()); else passed++;
      checks++; if (xfer_data.size() !== 2) $display("FAIL stream_words got %0d want 2", xfer_data.size()); else passed++;
      if (pop_cyc.size() == 4 && xfer_data.size() == 2) begin
         checks++; if (pop_cyc[3] - pop_cyc[0] !== 3) $display("FAIL stream_pop_span got %0d want 3", pop_cyc[3] - pop_cyc[0]); else passed++;
         checks++; if (xfer_data[0] !== 32'h22221111) $display("FAIL stream_w0 got %h want 22221111", xfer_data[0]); else passed++;
         checks++; if (xfer_data[1] !== 32'h44443333) $display("FAIL stream_w1 got %h want 44443333", xfer_data[1]); else passed++;
         checks++; if (xfer_part[0] !== 1'b0 || xfer_part[1] !== 1'b0) $display("FAIL stream_partial got %b%b want 00", xfer_part[0], xfer_part[1]); else passed++;
         checks++; if (xfer_cyc[1] - xfer_cyc[0] !== 2) $display("FAIL stream_gap got %0d want 2", xfer_cyc[1] - xfer_cyc[0]); else passed++;
         checks++; if (xfer_cyc[0] - pop_cyc[0] !== 3) $display("FAIL stream_latency got %0d want 3", xfer_cyc[0] - pop_cyc[0]); else passed++;
      end
      checks++; if (bus.out_count !== 16'd2) $display("FAIL stream_count got %0d want 2", bus.out_count); else passed++;
   endtask

   task automatic test_backpressure();
      logic [15:0] w[8];
      do_reset();
      for (int i = 0; i < 8; i++) begin
         w[i] = 16'($urandom);
         push_word(w[i]);
      end
      repeat (10) cycle();
      checks++; if (pop_cyc.size() !== 3) $display("FAIL bp_stall_pops got %0d want 3", pop_cyc.size()); else passed++;
      checks++; if (xfer_data.size() !== 0) $display("FAIL bp_stall_xfers got %0d want 0", xfer_data.size()); else passed++;
      checks++; if (s_valid !== 1'b1) $display("FAIL bp_stall_valid got %b want 1", s_valid); else passed++;
      checks++; if (s_data !== {w[1], w[0]}) $display("FAIL bp_stall_data got %h want %h", s_data, {w[1], w[0]}); else passed++;
      checks++; if (stall_err !== 0) $display("FAIL bp_stable got %0d unstable cycles want 0", stall_err); else passed++;
      bus.out_ready = 1'b1;
      repeat (20) cycle();
      checks++; if (xfer_data.size() !== 4) $display("FAIL bp_words got %0d want 4", xfer_data.size()); else passed++;
      for (int i = 0; i < 4 && i < xfer_data.size(); i++) begin
         checks++; if (xfer_data[i] !== {w[2*i+1], w[2*i]} || xfer_part[i] !== 1'b0)
            $display("FAIL bp_word%0d got %h/%b want %h/0", i, xfer_data[i], xfer_part[i], {w[2*i+1], w[2*i]});
         else passed++;
      end
      checks++; if (pop_cyc.size() !== 8) $display("FAIL bp_pops got %0d want 8", pop_cyc.size()); else passed++;
      checks++; if (bus.out_count !== 16'd4) $display("FAIL bp_count got %0d want 4", bus.out_count); else passed++;
   endtask

   task automatic test_flush();
      do_reset();
      push_word(16'h000A); push_word(16'h000B); push_word(16'h000C);
      bus.out_ready = 1'b1;
      repeat (8) cycle();
      checks++; if (pop_cyc.size() !== 3) $display("FAIL flush_pre_pops got %0d want 3", pop_cyc.size()); else passed++;
      checks++; if (xfer_data.size() !== 1) $display("FAIL flush_pre_words got %0d want 1", xfer_data.size()); else passed++;
      if (xfer_data.size() >= 1) begin
         checks++; if (xfer_data[0] !== 32'h000B000A || xfer_part[0] !== 1'b0)
            $display("FAIL flush_full got %h/%b want 000b000a/0", xfer_data[0], xfer_part[0]); else passed++;
      end
      bus.flush = 1'b1;
      repeat (4) cycle();
      checks++; if (xfer_data.size() !== 2) $display("FAIL flush_words got %0d want 2", xfer_data.size()); else passed++;
      if (xfer_data.size() >= 2) begin
         checks++; if (xfer_data[1] !== 32'h0000000C || xfer_part[1] !== 1'b1)
            $display("FAIL flush_partial got %h/%b want 0000000c/1", xfer_data[1], xfer_part[1]); else passed++;
      end
      push_word(16'h000D);
      repeat (5) cycle();
      checks++; if (pop_cyc.size() !== 3) $display("FAIL flush_blocks_pop got %0d want 3", pop_cyc.size()); else passed++;
      checks++; if (xfer_data.size() !== 2) $display("FAIL flush_idle got %0d want 2", xfer_data.size()); else passed++;
      bus.flush = 1'b0;
      push_word(16'h000E);
      repeat (8) cycle();
      checks++; if (xfer_data.size() !== 3) $display("FAIL flush_after_words got %0d want 3", xfer_data.size()); else passed++;
      if (xfer_data.size() >= 3) begin
         checks++; if (xfer_data[2] !== 32'h000E000D || xfer_part[2] !== 1'b0)
            $display("FAIL flush_after got %h/%b want 000e000d/0", xfer_data[2], xfer_part[2]); else passed++;
      end
      checks++; if (bus.out_count !== 16'd3) $display("FAIL flush_count got %0d want 3", bus.out_count); else passed++;
   endtask

   task automatic test_empty();
      do_reset();
      for (int i = 0; i < 100; i++) begin
         bus.out_ready = 1'($urandom);
         bus.flush     = 1'($urandom);
         cycle();
      end
      bus.flush = 1'b0;
      checks++; if (pop_cyc.size() !== 0) $display("FAIL empty_pops got %0d want 0", pop_cyc.size()); else passed++;
      checks++; if (underflow_cnt !== 0) $display("FAIL empty_underflow got %0d want 0", underflow_cnt); else passed++;
      checks++; if (xfer_data.size() !== 0 || s_valid !== 1'b0) $display("FAIL empty_out got %0d words valid=%b want 0/0", xfer_data.size(), s_valid); else passed++;
   endtask

   task automatic test_random();
      localparam int N = 41;
      logic [15:0] w[N];
      int          idx;
      do_reset();
      for (int i = 0; i < N; i++) w[i] = 16'($urandom);
      idx = 0;
      for (int c = 0; c < 3000 && !(idx == N && pop_cyc.size() == N && xfer_data.size() == N/2); c++) begin
         if (idx < N && ($urandom % 3) != 0) begin
            push_word(w[idx]);
            idx++;
         end
         bus.out_ready = (($urandom % 4) != 0);
         cycle();
      end
      bus.out_ready = 1'b1;
      repeat (3) cycle();
      checks++; if (xfer_data.size() !== N/2) $display("FAIL rand_words got %0d want %0d", xfer_data.size(), N/2); else passed++;
      bus.flush = 1'b1;
      repeat (4) cycle();
      bus.flush = 1'b0;
      checks++; if (xfer_data.size() !== N/2 + 1) $display("FAIL rand_total got %0d want %0d", xfer_data.size(), N/2 + 1); else passed++;
      for (int i = 0; i < N/2 && i < xfer_data.size(); i++) begin
         checks++; if (xfer_data[i] !== {w[2*i+1], w[2*i]} || xfer_part[i] !== 1'b0)
            $display("FAIL rand_word%0d got %h/%b want %h/0", i, xfer_data[i], xfer_part[i], {w[2*i+1], w[2*i]});
         else passed++;
      end
      if (xfer_data.size() > N/2) begin
         checks++; if (xfer_data[N/2] !== {16'h0000, w[N-1]} || xfer_part[N/2] !== 1'b1)
            $display("FAIL rand_tail got %h/%b want %h/1", xfer_data[N/2], xfer_part[N/2], {16'h0000, w[N-1]});
         else passed++;
      end
      checks++; if (stall_err !== 0) $display("FAIL rand_stable got %0d want 0", stall_err); else passed++;
      checks++; if (underflow_cnt !== 0) $display("FAIL rand_underflow got %0d want 0", underflow_cnt); else passed++;
      checks++; if (pop_cyc.size() !== N) $display("FAIL rand_pops got %0d want %0d", pop_cyc.size(), N); else passed++;
      checks++; if (bus.out_count !== 16'(N/2 + 1)) $display("FAIL rand_count got %0d want %0d", bus.out_count, N/2 + 1); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      push_word(16'hAAAA);
      push_word(16'hBBBB);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && pop_cyc.size() == 0; i++) cycle();
      checks++; if (pop_cyc.size() !== 1) $display("FAIL midrst_first_pop got %0d want 1", pop_cyc.size()); else passed++;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      clear_obs();
      bus.flush = 1'b1;
      cycle();
      checks++; if (s_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", s_valid); else passed++;
      repeat (3) cycle();
      checks++; if (xfer_data.size() !== 0) $display("FAIL midrst_lo_held got %0d words want 0", xfer_data.size()); else passed++;
      bus.flush = 1'b0;
      push_word(16'hCCCC);
      repeat (8) cycle();
      checks++; if (xfer_data.size() !== 1) $display("FAIL midrst_words got %0d want 1", xfer_data.size()); else passed++;
      if (xfer_data.size() >= 1) begin
         checks++; if (xfer_data[0] !== 32'hCCCCBBBB || xfer_part[0] !== 1'b0)
            $display("FAIL midrst_word got %h/%b want ccccbbbb/0", xfer_data[0], xfer_part[0]); else passed++;
      end
      checks++; if (bus.out_count !== 16'd1) $display("FAIL midrst_count got %0d want 1", bus.out_count); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      bus.fifo_empty    = 1'b1;
      bus.fifo_data_out = '0;
      bus.out_ready     = 1'b0;
      bus.flush         = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_empty();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d cycles", cyc);
      $fatal(1, "watchdog");
   end

endmodule
